rtc_lectura_ad: RTL and testbench

Read-transaction controller for the RTC's multiplexed address/data bus. It is the read-side counterpart of the up/down setting counters (hour, date, day of week) that feed the write path. On a rising edge of `start`, it performs one complete RTC read: an address phase, a bus turnaround, then a data phase. It then returns the captured byte with a one-cycle `done` pulse so the display/BCD logic can consume it.

---
 rtl/rtc_lectura_ad_pkg.sv | 34 +++
 rtl/rtc_lectura_ad_temporizador_fase.sv | 31 +++
 rtl/rtc_lectura_ad.sv | 202 ++++++++++++++++++++
 tb/tb_rtc_lectura_ad.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rtc_lectura_ad_pkg.sv
// Shared definitions for the RTC read-transaction controller.
//   estado_t          FSM state encoding of rtc_lectura_ad
//   T_*_DEF           default strobe / phase widths in clk cycles
//   RTC_DIR_*         RTC register addresses (clock/calendar map)
//   max_int           helper used to size the phase timer
package rtc_lectura_ad_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ADDR_SETUP = 3'd1,
        ADDR_WR    = 3'd2,
        ADDR_HOLD  = 3'd3,
        TURN       = 3'd4,
        DATA_RD    = 3'd5,
        DATA_HOLD  = 3'd6,
        DONE       = 3'd7
    } estado_t;

    localparam int T_PULSO_DEF  = 10;
    localparam int T_ESPERA_DEF = 4;

    localparam logic [7:0] RTC_DIR_SEGUNDOS = 8'h00;
    localparam logic [7:0] RTC_DIR_MINUTOS  = 8'h02;
    localparam logic [7:0] RTC_DIR_HORAS    = 8'h04;
    localparam logic [7:0] RTC_DIR_DIA_SEM  = 8'h06;
    localparam logic [7:0] RTC_DIR_FECHA    = 8'h07;
    localparam logic [7:0] RTC_DIR_MES      = 8'h08;
    localparam logic [7:0] RTC_DIR_ANIO     = 8'h09;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rtc_lectura_ad_temporizador_fase.sv
// Loadable phase down-counter shared by all timed states.
//   clk, reset  clock, synchronous active-high reset
//   carga       load `valor` this edge (state entry)
//   valor       phase length in cycles (>= 1)
//   fin         high in the last cycle of the loaded phase
module temporizador_fase #(
    parameter int ANCHO = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             carga,
    input  logic [ANCHO-1:0] valor,
    output logic             fin
);

    logic [ANCHO-1:0] cuenta;

    always_ff @(posedge clk) begin
        if (reset) begin
            cuenta <= '0;
        end else if (carga) begin
            cuenta <= valor;
        end else if (cuenta != '0) begin
            cuenta <= cuenta - ANCHO'(1);
        end
    end

    // Loading N makes the count read N..1 over N cycles; 1 marks the last one.
    assign fin = (cuenta == ANCHO'(1));

endmodule

// File: rtl/rtc_lectura_ad.sv
// RTC read-transaction controller for the multiplexed AD bus.
// A rising edge on `start` runs address phase, turnaround and data phase,
// then presents the captured byte on `data_out` with a one-cycle `done`.
//   clk, reset        clock, synchronous active-high reset
//   start, addr       request level and register address (sampled at launch)
//   ad_in             AD bus value from the pad
//   ad_out, ad_oe     AD bus drive value and output enable
//   cs_n, rd_n, wr_n  RTC strobes, active-low
//   ad_sel            0 = address cycle, 1 = data cycle
//   data_out, done    captured byte, one-cycle update pulse
//   busy              transaction in progress
//
// state      | meaning
// -----------+---------------------------------------------
// IDLE       | bus released, waiting for a start edge
// ADDR_SETUP | address driven, cs_n low, before wr_n
// ADDR_WR    | wr_n low, RTC latches the address
// ADDR_HOLD  | address held after wr_n rises
// TURN       | bus released, cs_n high, turnaround
// DATA_RD    | rd_n low, RTC drives the bus
// DATA_HOLD  | rd_n high, cs_n still low
// DONE       | data_out valid, done pulse
module rtc_lectura_ad
    import rtc_lectura_ad_pkg::*;
#(
    parameter int T_PULSO  = T_PULSO_DEF,
    parameter int T_ESPERA = T_ESPERA_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] addr,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       ad_sel,
    output logic [7:0] data_out,
    output logic       busy,
    output logic       done
);

    localparam int ANCHO = $clog2(max_int(T_PULSO, T_ESPERA) + 1);
    localparam logic [ANCHO-1:0] DUR_PULSO  = ANCHO'(T_PULSO);
    localparam logic [ANCHO-1:0] DUR_ESPERA = ANCHO'(T_ESPERA);
    localparam logic [ANCHO-1:0] DUR_DONE   = ANCHO'(1);

    estado_t          estado, estado_sig;
    logic             start_reg;
    logic             lanzar;
    logic [7:0]       addr_lat;
    logic             carga;
    logic [ANCHO-1:0] valor;
    logic             fin;

    // Only a fresh low->high edge seen in IDLE launches; edges during a
    // transaction are dropped, and a level still high afterwards is not an edge.
    assign lanzar = start & ~start_reg & (estado == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            estado    <= IDLE;
            start_reg <= 1'b1;
            addr_lat  <= '0;
            data_out  <= '0;
        end else begin
            estado    <= estado_sig;
            start_reg <= start;
            if (lanzar) begin
                addr_lat <= addr;
            end
            // Sample while rd_n is still low, on the edge that ends DATA_RD.
            if (estado == DATA_RD && fin) begin
                data_out <= ad_in;
            end
        end
    end

    temporizador_fase #(
        .ANCHO (ANCHO)
    ) u_temporizador_fase (
        .clk   (clk),
        .reset (reset),
        .carga (carga),
        .valor (valor),
        .fin   (fin)
    );

    always_comb begin
        estado_sig = estado;
        carga      = 1'b0;
        valor      = DUR_ESPERA;
        case (estado)
            IDLE: begin
                if (lanzar) begin
                    estado_sig = ADDR_SETUP;
                    carga      = 1'b1;
                    valor      = DUR_ESPERA;
                end
            end
            ADDR_SETUP: begin
                if (fin) begin
                    estado_sig = ADDR_WR;
                    carga      = 1'b1;
                    valor      = DUR_PULSO;
                end
            end
            ADDR_WR: begin
                if (fin) begin
                    estado_sig = ADDR_HOLD;
                    carga      = 1'b1;
                    valor      = DUR_ESPERA;
                end
            end
            ADDR_HOLD: begin
                if (fin) begin
                    estado_sig = TURN;
                    carga      = 1'b1;
                    valor      = DUR_ESPERA;
                end
            end
            TURN: begin
                if (fin) begin
                    estado_sig = DATA_RD;
                    carga      = 1'b1;
                    valor      = DUR_PULSO;
                end
            end
            DATA_RD: begin
                if (fin) begin
                    estado_sig = DATA_HOLD;
                    carga      = 1'b1;
                    valor      = DUR_ESPERA;
                end
            end
            DATA_HOLD: begin
                if (fin) begin
                    estado_sig = DONE;
                    carga      = 1'b1;
                    valor      = DUR_DONE;
                end
            end
            DONE: begin
                if (fin) begin
                    estado_sig = IDLE;
                end
            end
            default: begin
                estado_sig = IDLE;
            end
        endcase
    end

    always_comb begin
        cs_n   = 1'b1;
        rd_n   = 1'b1;
        wr_n   = 1'b1;
        ad_sel = 1'b0;
        ad_oe  = 1'b0;
        ad_out = '0;
        busy   = 1'b1;
        done   = 1'b0;
        case (estado)
            IDLE: begin
                busy = 1'b0;
            end
            ADDR_SETUP, ADDR_HOLD: begin
                cs_n   = 1'b0;
                ad_oe  = 1'b1;
                ad_out = addr_lat;
            end
            ADDR_WR: begin
                cs_n   = 1'b0;
                wr_n   = 1'b0;
                ad_oe  = 1'b1;
                ad_out = addr_lat;
            end
            TURN: begin
                ad_sel = 1'b1;
            end
            DATA_RD: begin
                cs_n   = 1'b0;
                rd_n   = 1'b0;
                ad_sel = 1'b1;
            end
            DATA_HOLD: begin
                cs_n   = 1'b0;
                ad_sel = 1'b1;
            end
            DONE: begin
                busy = 1'b0;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rtc_lectura_ad.sv
module tb_rtc_lectura_ad;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start;
    logic       usar_c;
    logic [7:0] addr;
    logic [7:0] dato;

    logic       start_a, start_c;
    logic [7:0] ad_in_a, ad_in_c, ad_out_a, ad_out_c, data_out_a, data_out_c;
    logic       ad_oe_a, cs_n_a, rd_n_a, wr_n_a, ad_sel_a, busy_a, done_a;
    logic       ad_oe_c, cs_n_c, rd_n_c, wr_n_c, ad_sel_c, busy_c, done_c;

    assign start_a = usar_c ? 1'b0 : start;
    assign start_c = usar_c ? start : 1'b0;
    // RTC model: drives the byte only while rd_n is low, its complement otherwise.
    assign ad_in_a = (!rd_n_a) ? dato : ~dato;
    assign ad_in_c = (!rd_n_c) ? dato : ~dato;

    rtc_lectura_ad dut (
        .clk(clk), .reset(reset), .start(start_a), .addr(addr), .ad_in(ad_in_a),
        .ad_out(ad_out_a), .ad_oe(ad_oe_a), .cs_n(cs_n_a), .rd_n(rd_n_a), .wr_n(wr_n_a),
        .ad_sel(ad_sel_a), .data_out(data_out_a), .busy(busy_a), .done(done_a)
    );

    rtc_lectura_ad #(.T_PULSO(1), .T_ESPERA(1)) dut_c (
        .clk(clk), .reset(reset), .start(start_c), .addr(addr), .ad_in(ad_in_c),
        .ad_out(ad_out_c), .ad_oe(ad_oe_c), .cs_n(cs_n_c), .rd_n(rd_n_c), .wr_n(wr_n_c),
        .ad_sel(ad_sel_c), .data_out(data_out_c), .busy(busy_c), .done(done_c)
    );

    logic [7:0] o_ad_out, o_data_out;
    logic       o_ad_oe, o_cs_n, o_rd_n, o_wr_n, o_ad_sel, o_busy, o_done;
    always_comb begin
        o_ad_out   = usar_c ? ad_out_c   : ad_out_a;
        o_data_out = usar_c ? data_out_c : data_out_a;
        o_ad_oe    = usar_c ? ad_oe_c    : ad_oe_a;
        o_cs_n     = usar_c ? cs_n_c     : cs_n_a;
        o_rd_n     = usar_c ? rd_n_c     : rd_n_a;
        o_wr_n     = usar_c ? wr_n_c     : wr_n_a;
        o_ad_sel   = usar_c ? ad_sel_c   : ad_sel_a;
        o_busy     = usar_c ? busy_c     : busy_a;
        o_done     = usar_c ? done_c     : done_a;
    end

    int total = 0;
    int pasados = 0;
    int viol = 0;

    always @(negedge clk) begin
        if ((ad_oe_a && !rd_n_a) || (!wr_n_a && !rd_n_a) ||
            (ad_oe_c && !rd_n_c) || (!wr_n_c && !rd_n_c))
            viol++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) pasados++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    endtask

    task automatic ciclo();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        bit         c;
    } vec_t;

    // One full read; optionally re-pulses start at cycles 14/15 and then checks
    // that nothing relaunches while start stays high.
    task automatic leer(input logic [7:0] a, input logic [7:0] d, input bit c,
                        input bit retrig, input string nm);
        int tp, te, largo, cnt_wr, cnt_rd, mal_ad, ciclo_done, busy1, sel1, dout;
        int extra_done, extra_busy;
        tp = c ? 1 : 10;
        te = c ? 1 : 4;
        largo = 4 * te + 2 * tp + 1;
        usar_c = c;
        addr = a;
        dato = d;
        start = 1'b0;
        ciclo();
        start = 1'b1;
        cnt_wr = 0; cnt_rd = 0; mal_ad = 0; ciclo_done = 0; busy1 = 0; sel1 = 1; dout = 0;
        for (int cyc = 1; cyc <= 150 && ciclo_done == 0; cyc++) begin
            ciclo();
            if (cyc == 1) begin
                busy1 = o_busy;
                sel1  = o_ad_sel;
            end
            if (cyc == 3) addr = ~a;
            if (!o_wr_n) begin
                cnt_wr++;
                if (o_ad_out != a || !o_ad_oe) mal_ad++;
            end
            if (!o_rd_n) cnt_rd++;
            if (o_done) begin
                ciclo_done = cyc;
                dout = o_data_out;
            end
            if (retrig && cyc == 14) start = 1'b0;
            if (retrig && cyc == 15) start = 1'b1;
        end
        chk({nm, " busy_first"}, busy1, 1);
        chk({nm, " ad_sel_first"}, sel1, 0);
        chk({nm, " length"}, ciclo_done, largo);
        chk({nm, " wr_n_low"}, cnt_wr, tp);
        chk({nm, " rd_n_low"}, cnt_rd, tp);
        chk({nm, " addr_on_bus"}, mal_ad, 0);
        chk({nm, " data_at_done"}, dout, int'(d));
        ciclo();
        chk({nm, " idle_after"}, {o_busy, o_done, o_cs_n, o_ad_oe}, 4'b0010);
        if (retrig) begin
            extra_done = 0;
            extra_busy = 0;
            for (int i = 0; i < 50; i++) begin
                ciclo();
                if (o_done) extra_done++;
                if (o_busy) extra_busy++;
            end
            chk({nm, " no_relaunch_done"}, extra_done, 0);
            chk({nm, " no_relaunch_busy"}, extra_busy, 0);
        end
        chk({nm, " data_hold"}, o_data_out, int'(d));
        start = 1'b0;
    endtask

    vec_t tabla[6];

    initial begin
        int hubo_busy, hubo_done;
        tabla[0] = '{a: 8'h06, d: 8'h05, c: 1'b0};
        tabla[1] = '{a: 8'h00, d: 8'hFF, c: 1'b0};
        tabla[2] = '{a: 8'hA5, d: 8'h5A, c: 1'b0};
        tabla[3] = '{a: 8'h3C, d: 8'hC3, c: 1'b0};
        tabla[4] = '{a: 8'h12, d: 8'h34, c: 1'b1};
        tabla[5] = '{a: 8'hFF, d: 8'h81, c: 1'b1};

        usar_c = 1'b0; start = 1'b0; addr = 8'h00; dato = 8'h00; reset = 1'b1;
        repeat (3) ciclo();
        reset = 1'b0;
        repeat (20) ciclo();
        chk("reset strobes", {cs_n_a, rd_n_a, wr_n_a}, 3'b111);
        chk("reset ad_oe_sel", {ad_oe_a, ad_sel_a}, 2'b00);
        chk("reset busy_done", {busy_a, done_a}, 2'b00);
        chk("reset data_out", data_out_a, 0);
        chk("reset ad_out", ad_out_a, 0);
        chk("reset data_out_c", data_out_c, 0);

        // start held high through reset release must not launch
        reset = 1'b1; start = 1'b1;
        ciclo();
        reset = 1'b0;
        hubo_busy = 0;
        for (int i = 0; i < 45; i++) begin
            ciclo();
            if (busy_a || done_a) hubo_busy++;
        end
        chk("held_start no_launch", hubo_busy, 0);
        start = 1'b0;

        for (int i = 0; i < 6; i++)
            leer(tabla[i].a, tabla[i].d, tabla[i].c, 1'b0, $sformatf("vec%0d", i));

        leer(8'h04, 8'h17, 1'b0, 1'b1, "retrig");

        for (int i = 0; i < 10; i++)
            leer(8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)), 1'b0, 1'b0,
                 $sformatf("rnd%0d", i));

        // reset during DATA_RD
        usar_c = 1'b0; addr = 8'h09; dato = 8'h00; start = 1'b0;
        ciclo();
        start = 1'b1;
        repeat (25) ciclo();
        chk("midreset in_data_rd", rd_n_a, 0);
        reset = 1'b1;
        ciclo();
        chk("midreset strobes", {cs_n_a, rd_n_a, wr_n_a}, 3'b111);
        chk("midreset bus", {ad_oe_a, ad_sel_a, busy_a, done_a}, 4'b0000);
        chk("midreset data_out", data_out_a, 0);
        reset = 1'b0;
        hubo_done = 0;
        for (int i = 0; i < 40; i++) begin
            ciclo();
            if (done_a || busy_a) hubo_done++;
        end
        chk("midreset no_done", hubo_done, 0);
        start = 1'b0;
        ciclo();

        chk("bus contention", viol, 0);
        $display("%0d/%0d checks passed", pasados, total);
        $finish;
    end

endmodule
